mem_ctrl: RTL and testbench

Memory and I/O controller directly downstream of the CPU's memory port. It decodes the CPU's `mem_cmd`/`mem_addr`/`write_data` bus, serves a 256×16 synchronous RAM, and exposes memory-mapped LED, switch, timer and status registers. It returns registered `read_data` one cycle after each read command.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/ram_256x16.sv | 24 ++
 rtl/mem_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared command codes, I/O address map and response FSM states
package mem_ctrl_pkg;

  localparam int unsigned RAM_WORDS = 256;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MILL   = 2'b11;

  localparam logic [8:0] ADDR_LED    = 9'h100;
  localparam logic [8:0] ADDR_SW     = 9'h140;
  localparam logic [8:0] ADDR_TIMER  = 9'h180;
  localparam logic [8:0] ADDR_STATUS = 9'h1C0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } resp_state_t;

endpackage

// File: rtl/ram_256x16.sv
// rtl/ram_256x16.sv - single-port 256x16 synchronous RAM, registered read, contents not reset
module ram_256x16
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);

  logic [15:0] mem_q [RAM_WORDS];
  logic [15:0] rdata_q;

  // Output register only loads on reads so it holds across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - CPU memory/I-O controller: RAM, LED, SW, STATUS; TIMER built when MEM_CTRL_TIMER_EN is defined
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ready,
  input  logic [7:0]  SW,
  output logic [7:0]  LEDR,
  output logic        bus_err
);

  resp_state_t state_q, state_d;
  logic        is_rd, is_wr, accepted;
  logic        hit_ram, hit_led, hit_sw, hit_tmr, hit_stat, unmapped;
  logic        err_set, err_clr;
  logic [15:0] io_rdata;
  logic [15:0] ram_rdata;
  logic        read_src_q, read_src_d;
  logic [15:0] io_q, io_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic        bus_err_q, bus_err_d;

`ifdef MEM_CTRL_TIMER_EN
  logic [15:0] timer_q, timer_d;
`endif

  always_comb begin
    is_rd    = (mem_cmd == MREAD);
    is_wr    = (mem_cmd == MWRITE);
    accepted = is_rd | is_wr;
    hit_ram  = ~mem_addr[8];
    hit_led  = (mem_addr == ADDR_LED);
    hit_sw   = (mem_addr == ADDR_SW);
    hit_stat = (mem_addr == ADDR_STATUS);
`ifdef MEM_CTRL_TIMER_EN
    hit_tmr  = (mem_addr == ADDR_TIMER);
`else
    hit_tmr  = 1'b0;
`endif
    unmapped = mem_addr[8] & ~(hit_led | hit_sw | hit_tmr | hit_stat);
  end

  always_comb begin
    io_rdata = 16'h0000;
    if (hit_led)  io_rdata = {8'h00, led_q};
    if (hit_sw)   io_rdata = {8'h00, sw_sync_q};
    if (hit_stat) io_rdata = {15'b0, bus_err_q};
`ifdef MEM_CTRL_TIMER_EN
    if (hit_tmr)  io_rdata = timer_q;
`endif
  end

  // read_data is a mux of two registers: the RAM output register or the I/O capture register.
  always_comb begin
    read_src_d = read_src_q;
    io_d       = io_q;
    led_d      = led_q;
    if (is_rd) begin
      read_src_d = hit_ram;
      if (!hit_ram) io_d = io_rdata;
    end
    if (is_wr && hit_led) led_d = write_data[7:0];

    err_set   = (mem_cmd == MILL) | (accepted & unmapped) | (is_wr & hit_sw);
    err_clr   = is_wr & hit_stat;
    bus_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : bus_err_q);
  end

  always_comb begin
    state_d   = state_q;
    mem_ready = 1'b0;
    case (state_q)
      S_IDLE: if (accepted) state_d = S_RESP;
      S_RESP: begin
        mem_ready = 1'b1;
        state_d   = accepted ? S_RESP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      read_src_q <= 1'b0;
      io_q       <= 16'h0000;
      led_q      <= 8'h00;
      sw_meta_q  <= 8'h00;
      sw_sync_q  <= 8'h00;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_src_q <= read_src_d;
      io_q       <= io_d;
      led_q      <= led_d;
      sw_meta_q  <= SW;
      sw_sync_q  <= sw_meta_q;
      bus_err_q  <= bus_err_d;
    end
  end

`ifdef MEM_CTRL_TIMER_EN
  always_comb begin
    timer_d = timer_q + 16'd1;
    if (is_wr && hit_tmr) timer_d = write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= 16'h0000;
    else       timer_q <= timer_d;
  end
`endif

  ram_256x16 u_ram (
    .clk     (clk),
    .we_i    (is_wr & hit_ram),
    .re_i    (is_rd & hit_ram),
    .addr_i  (mem_addr[7:0]),
    .wdata_i (write_data),
    .rdata_o (ram_rdata)
  );

  assign read_data = read_src_q ? ram_rdata : io_q;
  assign LEDR      = led_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = MNONE;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;
  logic        mem_ready;
  logic [7:0]  SW = 8'h00;
  logic [7:0]  LEDR;
  logic        bus_err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  mem_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .SW         (SW),
    .LEDR       (LEDR),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = data;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_read_data", read_data, 16'h0000);
    check("rst_mem_ready", {15'b0, mem_ready}, 16'h0000);
    check("rst_ledr", {8'h00, LEDR}, 16'h0000);
    check("rst_bus_err", {15'b0, bus_err}, 16'h0000);
    reset = 1'b0;
    tick();
    check("idle_ready", {15'b0, mem_ready}, 16'h0000);

    drive(MWRITE, 9'h005, 16'hBEEF);
    tick();
    check("ram_wr_ready", {15'b0, mem_ready}, 16'h0001);
    drive(MREAD, 9'h005, 16'h0000);
    tick();
    check("ram_rd_data", read_data, 16'hBEEF);
    check("ram_rd_ready", {15'b0, mem_ready}, 16'h0001);
    check("ram_rd_err", {15'b0, bus_err}, 16'h0000);
    drive(MNONE, 9'h000, 16'h0000);
    tick();
    check("idle_after_rd", {15'b0, mem_ready}, 16'h0000);
    check("hold_idle", read_data, 16'hBEEF);

    drive(MWRITE, 9'h0FF, 16'h1234);
    tick();
    drive(MREAD, 9'h0FF, 16'h0000);
    tick();
    check("ram_top_word", read_data, 16'h1234);

    drive(MWRITE, 9'h100, 16'h00A5);
    SW = 8'h3C;
    tick();
    check("led_value", {8'h00, LEDR}, 16'h00A5);
    check("hold_over_wr", read_data, 16'h1234);
    drive(MREAD, 9'h100, 16'h0000);
    tick();
    check("led_read", read_data, 16'h00A5);

    drive(MNONE, 9'h000, 16'h0000);
    tick();
    drive(MREAD, 9'h140, 16'h0000);
    tick();
    check("sw_read", read_data, 16'h003C);
    drive(MWRITE, 9'h140, 16'hFFFF);
    tick();
    check("sw_wr_err", {15'b0, bus_err}, 16'h0001);
    drive(MREAD, 9'h1C0, 16'h0000);
    tick();
    check("status_read", read_data, 16'h0001);
    drive(MWRITE, 9'h1C0, 16'h0000);
    tick();
    check("status_clear", {15'b0, bus_err}, 16'h0000);

`ifdef MEM_CTRL_TIMER_EN
    drive(MWRITE, 9'h180, 16'hFFFE);
    tick();
    drive(MNONE, 9'h000, 16'h0000);
    tick();
    drive(MREAD, 9'h180, 16'h0000);
    tick();
    check("timer_ffff", read_data, 16'hFFFF);
    tick();
    check("timer_wrap", read_data, 16'h0000);
    check("timer_err", {15'b0, bus_err}, 16'h0000);
`else
    drive(MREAD, 9'h180, 16'h0000);
    tick();
    check("notimer_read", read_data, 16'h0000);
    check("notimer_err", {15'b0, bus_err}, 16'h0001);
    drive(MWRITE, 9'h1C0, 16'h0000);
    tick();
    check("notimer_clr", {15'b0, bus_err}, 16'h0000);
`endif

    drive(MREAD, 9'h005, 16'h0000);
    tick();
    check("ram_reread", read_data, 16'hBEEF);
    drive(MREAD, 9'h1FF, 16'h0000);
    tick();
    check("unmap_read", read_data, 16'h0000);
    check("unmap_ready", {15'b0, mem_ready}, 16'h0001);
    check("unmap_err", {15'b0, bus_err}, 16'h0001);
    drive(MWRITE, 9'h1C0, 16'h0000);
    tick();
    check("unmap_clr", {15'b0, bus_err}, 16'h0000);
    drive(MILL, 9'h005, 16'h0000);
    tick();
    check("illegal_ready", {15'b0, mem_ready}, 16'h0000);
    check("illegal_err", {15'b0, bus_err}, 16'h0001);
    check("illegal_hold", read_data, 16'h0000);

    drive(MWRITE, 9'h100, 16'h005A);
    tick();
    drive(MREAD, 9'h005, 16'h0000);
    tick();
    check("pre_rst_data", read_data, 16'hBEEF);
    drive(MREAD, 9'h010, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    check("async_ready", {15'b0, mem_ready}, 16'h0000);
    check("async_data", read_data, 16'h0000);
    check("async_led", {8'h00, LEDR}, 16'h0000);
    check("async_err", {15'b0, bus_err}, 16'h0000);
    tick();
    check("rst_drop_ready", {15'b0, mem_ready}, 16'h0000);
    check("rst_drop_data", read_data, 16'h0000);
    drive(MNONE, 9'h000, 16'h0000);
    #2;
    reset = 1'b0;
`ifdef MEM_CTRL_TIMER_EN
    drive(MREAD, 9'h180, 16'h0000);
    tick();
    check("timer_rst", read_data, 16'h0000);
    drive(MNONE, 9'h000, 16'h0000);
    tick();
`else
    tick();
`endif
    check("post_rst_ready", {15'b0, mem_ready}, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
